// File: rtl/reg_bus_pkg.sv
// -----------------------------------------------------------------------------
// reg_bus_pkg
// Shared types and defaults for the register-bus sequencing controller.
//   rbm_state_e  : controller states (idle, write strobe, read strobe, response)
//   RBM_NREG_DEF : default number of registers on the bus
//   RBM_W_DEF    : default data width
// -----------------------------------------------------------------------------
package reg_bus_pkg;

   typedef enum logic [1:0] {
      RBM_IDLE  = 2'd0,
      RBM_WRITE = 2'd1,
      RBM_READ  = 2'd2,
      RBM_RESP  = 2'd3
   } rbm_state_e;

   localparam int RBM_NREG_DEF = 8;
   localparam int RBM_W_DEF    = 16;

endpackage

// File: rtl/reg_bus_master_onehot_dec.sv
// -----------------------------------------------------------------------------
// onehot_dec
// Address to one-hot decoder with a global enable.
//   addr   in  AW   : register index
//   en     in  1    : when low, every output bit is 0
//   onehot out NREG : bit [addr] set when en is high
// -----------------------------------------------------------------------------
module onehot_dec #(
   parameter int NREG = 8,
   parameter int AW   = $clog2(NREG)
) (
   input  logic [AW-1:0]   addr,
   input  logic            en,
   output logic [NREG-1:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) begin
         onehot[addr] = 1'b1;
      end
   end

endmodule

// File: rtl/reg_bus_master.sv
// -----------------------------------------------------------------------------
// reg_bus_master
// Sequencer for a bank of tri-state registers: accepts one request per
// handshake (optional write + dual read), drives the load/oe strobes and the
// din bus, samples DA/DB and returns both operands over a valid/ready channel.
//
// Ports
//   clk, reset (async, active low)
//   req_valid/req_ready, req_we, req_wa, req_wd, req_ra, req_rb : request
//   rsp_valid/rsp_ready, rsp_da, rsp_db                          : response
//   load, oeA, oeB (one-hot, NREG), din (W)                      : register bus
//   DA, DB (W)                                                   : read buses
//
// Configuration macro
//   RBM_ZERO_REG_EN : register 0 reads as zero and ignores writes; no strobe
//                     is raised for address 0, timing is unchanged.
// -----------------------------------------------------------------------------
module reg_bus_master
   import reg_bus_pkg::*;
#(
   parameter int NREG = RBM_NREG_DEF,
   parameter int W    = RBM_W_DEF,
   parameter int AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [AW-1:0]   req_wa,
   input  logic [W-1:0]    req_wd,
   input  logic [AW-1:0]   req_ra,
   input  logic [AW-1:0]   req_rb,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [W-1:0]    rsp_da,
   output logic [W-1:0]    rsp_db,
   output logic [NREG-1:0] load,
   output logic [NREG-1:0] oeA,
   output logic [NREG-1:0] oeB,
   output logic [W-1:0]    din,
   input  logic [W-1:0]    DA,
   input  logic [W-1:0]    DB
);

   rbm_state_e    state_q,  state_d;
   logic [AW-1:0] wa_q,     wa_d;
   logic [W-1:0]  wd_q,     wd_d;
   logic [AW-1:0] ra_q,     ra_d;
   logic [AW-1:0] rb_q,     rb_d;
   logic [W-1:0]  rsp_da_q, rsp_da_d;
   logic [W-1:0]  rsp_db_q, rsp_db_d;

   logic          in_write;
   logic          in_read;
   logic          load_en;
   logic          oea_en;
   logic          oeb_en;
   logic [W-1:0]  cap_a;
   logic [W-1:0]  cap_b;

   assign in_write = (state_q == RBM_WRITE);
   assign in_read  = (state_q == RBM_READ);

   // Strobes come only from registered state and latched fields, so an
   // asynchronous reset (state -> IDLE) clears them immediately.
`ifdef RBM_ZERO_REG_EN
   assign load_en = in_write && (wa_q != '0);
   assign oea_en  = in_read  && (ra_q != '0);
   assign oeb_en  = in_read  && (rb_q != '0);
   assign cap_a   = (ra_q == '0) ? '0 : DA;
   assign cap_b   = (rb_q == '0) ? '0 : DB;
`else
   assign load_en = in_write;
   assign oea_en  = in_read;
   assign oeb_en  = in_read;
   assign cap_a   = DA;
   assign cap_b   = DB;
`endif

   onehot_dec #(.NREG(NREG), .AW(AW)) u_dec_load (
      .addr   (wa_q),
      .en     (load_en),
      .onehot (load)
   );

   onehot_dec #(.NREG(NREG), .AW(AW)) u_dec_oea (
      .addr   (ra_q),
      .en     (oea_en),
      .onehot (oeA)
   );

   onehot_dec #(.NREG(NREG), .AW(AW)) u_dec_oeb (
      .addr   (rb_q),
      .en     (oeb_en),
      .onehot (oeB)
   );

   assign din       = in_write ? wd_q : '0;
   assign req_ready = (state_q == RBM_IDLE);
   assign rsp_valid = (state_q == RBM_RESP);
   assign rsp_da    = rsp_da_q;
   assign rsp_db    = rsp_db_q;

   always_comb begin
      state_d  = state_q;
      wa_d     = wa_q;
      wd_d     = wd_q;
      ra_d     = ra_q;
      rb_d     = rb_q;
      rsp_da_d = rsp_da_q;
      rsp_db_d = rsp_db_q;
      case (state_q)
         RBM_IDLE: begin
            if (req_valid) begin
               wa_d    = req_wa;
               wd_d    = req_wd;
               ra_d    = req_ra;
               rb_d    = req_rb;
               state_d = req_we ? RBM_WRITE : RBM_READ;
            end
         end
         RBM_WRITE: begin
            state_d = RBM_READ;
         end
         RBM_READ: begin
            // Capture at the edge that closes the oe cycle; a preceding write
            // has already landed, so read-after-write returns the new data.
            rsp_da_d = cap_a;
            rsp_db_d = cap_b;
            state_d  = RBM_RESP;
         end
         RBM_RESP: begin
            if (rsp_ready) begin
               state_d = RBM_IDLE;
            end
         end
         default: begin
            state_d = RBM_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= RBM_IDLE;
         wa_q     <= '0;
         wd_q     <= '0;
         ra_q     <= '0;
         rb_q     <= '0;
         rsp_da_q <= '0;
         rsp_db_q <= '0;
      end else begin
         state_q  <= state_d;
         wa_q     <= wa_d;
         wd_q     <= wd_d;
         ra_q     <= ra_d;
         rb_q     <= rb_d;
         rsp_da_q <= rsp_da_d;
         rsp_db_q <= rsp_db_d;
      end
   end

endmodule

// File: tb/tb_reg_bus_master.sv
// -----------------------------------------------------------------------------
// tb_reg_bus_master
// Directed bench for reg_bus_master with an 8 x 16-bit register model on the
// bus. Undriven read buses float to 16'hDEAD so a missing oe is visible.
// -----------------------------------------------------------------------------
module tb_reg_bus_master;

   localparam int NREG = 8;
   localparam int W    = 16;
   localparam int AW   = 3;

   logic            clk;
   logic            reset;
   logic            req_valid;
   logic            req_ready;
   logic            req_we;
   logic [AW-1:0]   req_wa;
   logic [W-1:0]    req_wd;
   logic [AW-1:0]   req_ra;
   logic [AW-1:0]   req_rb;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [W-1:0]    rsp_da;
   logic [W-1:0]    rsp_db;
   logic [NREG-1:0] load;
   logic [NREG-1:0] oeA;
   logic [NREG-1:0] oeB;
   logic [W-1:0]    din;
   logic [W-1:0]    DA;
   logic [W-1:0]    DB;

   logic            model_init;
   logic [W-1:0]    regs [NREG];

   int checks;
   int failures;

   reg_bus_master #(.NREG(NREG), .W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_wa    (req_wa),
      .req_wd    (req_wd),
      .req_ra    (req_ra),
      .req_rb    (req_rb),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_da    (rsp_da),
      .rsp_db    (rsp_db),
      .load      (load),
      .oeA       (oeA),
      .oeB       (oeB),
      .din       (din),
      .DA        (DA),
      .DB        (DB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register model: preset values, then writes via load/din
   always @(posedge clk) begin
      for (int i = 0; i < NREG; i++) begin
         if (model_init) begin
            regs[i] <= W'(16'h1000 + i);
         end else if (load[i]) begin
            regs[i] <= din;
         end
      end
      if (model_init) begin
         regs[5] <= 16'h5555;
         regs[6] <= 16'h1234;
      end
   end

   always_comb begin
      DA = 16'hDEAD;
      DB = 16'hDEAD;
      for (int i = 0; i < NREG; i++) begin
         if (oeA[i]) DA = regs[i];
         if (oeB[i]) DB = regs[i];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic issue(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                        input logic [AW-1:0] ra, input logic [AW-1:0] rb);
      req_valid = 1'b1;
      req_we    = we;
      req_wa    = wa;
      req_wd    = wd;
      req_ra    = ra;
      req_rb    = rb;
   endtask

   task automatic drop_req();
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_wa    = '0;
      req_wd    = '0;
      req_ra    = '0;
      req_rb    = '0;
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      reset      = 1'b0;
      model_init = 1'b1;
      rsp_ready  = 1'b0;
      drop_req();

      // Reset held, then released
      nxt(); nxt();
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_da",    32'(rsp_da),    32'd0);
      reset      = 1'b1;
      model_init = 1'b0;
      nxt();
      chk("idle_req_ready", 32'(req_ready), 32'd1);
      chk("idle_strobes",   32'({load, oeA, oeB}), 32'd0);
      chk("idle_din",       32'(din), 32'd0);
      chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);

      // Write 3 <- A5C3, read ra=3 rb=5
      issue(1'b1, 3'd3, 16'hA5C3, 3'd3, 3'd5);
      nxt();                                       // WRITE cycle
      drop_req();
      chk("wr_load",     32'(load), 32'h08);
      chk("wr_din",      32'(din),  32'hA5C3);
      chk("wr_oe",       32'({oeA, oeB}), 32'd0);
      chk("wr_rsp_vld",  32'(rsp_valid), 32'd0);
      chk("wr_req_rdy",  32'(req_ready), 32'd0);
      nxt();                                       // READ cycle
      chk("rd_load",     32'(load), 32'd0);
      chk("rd_oeA",      32'(oeA),  32'h08);
      chk("rd_oeB",      32'(oeB),  32'h20);
      chk("rd_rsp_vld",  32'(rsp_valid), 32'd0);
      nxt();                                       // RESP (T0+2)
      chk("rsp_vld",     32'(rsp_valid), 32'd1);
      chk("rsp_da_raw",  32'(rsp_da), 32'hA5C3);
      chk("rsp_db_r5",   32'(rsp_db), 32'h5555);
      chk("rsp_strobes", 32'({load, oeA, oeB}), 32'd0);
      rsp_ready = 1'b1;
      nxt();
      rsp_ready = 1'b0;
      chk("post_rsp_vld", 32'(rsp_valid), 32'd0);
      chk("post_req_rdy", 32'(req_ready), 32'd1);

      // Read-only ra=1 rb=2 with 5 cycles of backpressure
      issue(1'b0, 3'd0, 16'h0000, 3'd1, 3'd2);
      nxt();                                       // READ
      drop_req();
      chk("bp_oeA",  32'(oeA),  32'h02);
      chk("bp_oeB",  32'(oeB),  32'h04);
      chk("bp_load", 32'(load), 32'd0);
      for (int c = 0; c < 5; c++) begin
         nxt();
         chk("bp_rsp_vld", 32'(rsp_valid), 32'd1);
         chk("bp_da",      32'(rsp_da), 32'h1001);
         chk("bp_db",      32'(rsp_db), 32'h1002);
         chk("bp_req_rdy", 32'(req_ready), 32'd0);
         chk("bp_strobes", 32'({load, oeA, oeB, din}), 32'd0);
      end
      // Release and offer the next request (ra==rb=6) at the same time
      rsp_ready = 1'b1;
      issue(1'b0, 3'd0, 16'h0000, 3'd6, 3'd6);
      nxt();                                       // back in IDLE
      rsp_ready = 1'b0;
      chk("bp_back_rdy", 32'(req_ready), 32'd1);
      chk("bp_back_oe",  32'({oeA, oeB}), 32'd0);
      nxt();                                       // READ of the new request
      drop_req();
      chk("same_oeA", 32'(oeA), 32'h40);
      chk("same_oeB", 32'(oeB), 32'h40);
      nxt();                                       // RESP at T0+1
      chk("same_vld", 32'(rsp_valid), 32'd1);
      chk("same_da",  32'(rsp_da), 32'h1234);
      chk("same_db",  32'(rsp_db), 32'h1234);
      rsp_ready = 1'b1;
      nxt();
      rsp_ready = 1'b0;

      // Reset asserted in the middle of READ
      issue(1'b0, 3'd0, 16'h0000, 3'd3, 3'd5);
      nxt();                                       // READ
      drop_req();
      chk("mr_oe_before", 32'({oeA, oeB}), 32'h0820);
      #1 reset = 1'b0;
      #1;
      chk("mr_oe_after",  32'({oeA, oeB}), 32'd0);
      chk("mr_req_rdy",   32'(req_ready), 32'd1);
      chk("mr_rsp_vld",   32'(rsp_valid), 32'd0);
      chk("mr_rsp_da",    32'(rsp_da), 32'd0);
      nxt(); nxt();
      reset = 1'b1;
      nxt();
      chk("mr_idle_rdy",  32'(req_ready), 32'd1);
      issue(1'b1, 3'd7, 16'h0BEE, 3'd7, 3'd3);
      nxt();                                       // WRITE
      drop_req();
      chk("mr_wr_load", 32'(load), 32'h80);
      nxt();                                       // READ
      chk("mr_rd_oe",   32'({oeA, oeB}), 32'h8008);
      nxt();                                       // RESP
      chk("mr_rsp_vld", 32'(rsp_valid), 32'd1);
      chk("mr_da",      32'(rsp_da), 32'h0BEE);
      chk("mr_db",      32'(rsp_db), 32'hA5C3);
      rsp_ready = 1'b1;
      nxt();
      rsp_ready = 1'b0;

      // Address 0: write FFFF then read it on both buses
      issue(1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0);
      nxt();                                       // WRITE
      drop_req();
`ifdef RBM_ZERO_REG_EN
      chk("z_load", 32'(load), 32'd0);
      nxt();                                       // READ
      chk("z_oe",   32'({oeA, oeB}), 32'd0);
      nxt();                                       // RESP
      chk("z_vld",  32'(rsp_valid), 32'd1);
      chk("z_da",   32'(rsp_da), 32'd0);
      chk("z_db",   32'(rsp_db), 32'd0);
`else
      chk("r0_load", 32'(load), 32'h01);
      nxt();                                       // READ
      chk("r0_oe",   32'({oeA, oeB}), 32'h0101);
      nxt();                                       // RESP
      chk("r0_vld",  32'(rsp_valid), 32'd1);
      chk("r0_da",   32'(rsp_da), 32'hFFFF);
      chk("r0_db",   32'(rsp_db), 32'hFFFF);
`endif
      rsp_ready = 1'b1;
      nxt();
      rsp_ready = 1'b0;
      chk("end_req_rdy", 32'(req_ready), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_bus_master.md
# reg_bus_master

Sequencing controller that sits on the register-file side opposite the 16-bit tri-state registers. It owns the per-register `load`, `oeA` and `oeB` strobes and the shared `din` write bus, and it samples the shared `DA`/`DB` read buses. A client issues one request per handshake: an optional write plus a dual read. The block returns both read operands over a valid/ready response channel.

## Interface
- `NREG`, 8: number of registers on the bus; power of two, ≥2
- `W`, 16: data width
- `AW`, $clog2(NREG): register address width (derived)

- `clk` in 1: system clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `req_valid` in 1: request offered
- `req_ready` out 1: block can accept a request
- `req_we` in 1: the request includes a write
- `req_wa` in AW: write address
- `req_wd` in W: write data
- `req_ra` in AW: read address for bus A
- `req_rb` in AW: read address for bus B
- `rsp_valid` out 1: read result available
- `rsp_ready` in 1: client accepts the result
- `rsp_da` out W: operand captured from DA
- `rsp_db` out W: operand captured from DB
- `load` out NREG: one-hot register load strobe
- `oeA` out NREG: one-hot output enable, bus A
- `oeB` out NREG: one-hot output enable, bus B
- `din` out W: write-data bus to all registers
- `DA` in W: shared tri-state read bus A
- `DB` in W: shared tri-state read bus B

## Operation
- States are IDLE, WRITE, READ and RESP.
- `req_ready = (state == IDLE)`.
- Accept when `req_valid && req_ready`. On accept, latch all request fields. Go to WRITE if `req_we`, otherwise go to READ.
- WRITE (1 cycle): `load[wa]=1`, `din=wd`; all other load bits are 0. Next state is READ.
- READ (1 cycle): `oeA[ra]=1`, `oeB[rb]=1`, one-hot each. `ra==rb` is legal: the same register drives both buses. At the closing edge, `rsp_da<=DA` and `rsp_db<=DB`. Next state is RESP.
- RESP: `rsp_valid=1`; `rsp_da`/`rsp_db` are held stable. When `rsp_ready` is seen, go to IDLE.
- Read-after-write: if `wa==ra` or `wa==rb`, the response carries the newly written data, because the write completes before READ.
- `load`, `oeA`, `oeB` and `din` decode only from the registered state and latched fields. They never depend combinationally on request inputs.
- Outside WRITE: `load=0`, `din=0`. Outside READ: `oeA=0`, `oeB=0`. No oe bit is ever active in two consecutive cycles.
- Reset (asynchronous, any state, including mid-WRITE or mid-READ) forces:
  - state = IDLE
  - `load`, `oeA`, `oeB`, `din`, `rsp_da`, `rsp_db` = 0
  - `rsp_valid` = 0
  - `req_ready` = 1 (it follows IDLE)
- A write aborted by reset may or may not have reached the register. The client must reissue it.

## Timing
- Accept at edge T0.
  - With write: WRITE during T0–T1, READ during T1–T2, `rsp_valid` from T2.
  - Without write: READ during T0–T1, `rsp_valid` from T1.
- `rsp_valid` → `rsp_ready` handshake at edge Tn returns to IDLE. `req_ready` rises in the same cycle; the next accept is possible at Tn+1.
- Peak throughput:
  - 1 request per 4 cycles with write
  - 1 request per 3 cycles read-only
- Backpressure: RESP holds indefinitely with outputs stable. No bus strobes are active during RESP.

## Configuration
- `RBM_ZERO_REG_EN` defined: register 0 is hardwired zero.
  - A write with `wa==0` passes through WRITE with `load=0`.
  - A read of address 0 asserts no oe bit on that bus, and the corresponding `rsp_*` captures 0 instead of the bus value.
  - Cycle timing is unchanged.
- `RBM_ZERO_REG_EN` undefined: address 0 is an ordinary register.

## Structure
- Package `reg_bus_pkg` holds:
  - the state enum (`RBM_IDLE`, `RBM_WRITE`, `RBM_READ`, `RBM_RESP`)
  - default `NREG` and `W` constants
- Sub-module `onehot_dec` (AW-bit address plus enable → NREG-bit one-hot) is instantiated three times: for load, oeA and oeB.

## Test plan
- Reset release, then idle:
  - `req_ready=1`; all strobes 0; `rsp_valid=0`.
- Write, then read back (NREG=8 register model on the bus):
  - Request we=1, wa=3, wd=16'hA5C3, ra=3, rb=5.
  - `load=8'b0000_1000` for exactly 1 cycle.
  - `oeA=8'h08` and `oeB=8'h20` for exactly 1 cycle.
  - `rsp_da=16'hA5C3`; `rsp_valid` at T0+2.
- Read-only with ra==rb=6 (register holds 16'h1234):
  - `oeA=oeB=8'h40`.
  - `rsp_da=rsp_db=16'h1234` at T0+1.
- Backpressure: hold `rsp_ready=0` for 5 cycles.
  - `rsp_*` stays stable; `req_ready=0`; no strobes.
  - After `rsp_ready`, a new request is accepted the next cycle.
- Assert `reset` low during READ:
  - `oeA`/`oeB` drop to 0 asynchronously; state IDLE.
  - A subsequent request completes normally.
- With `RBM_ZERO_REG_EN`: write wa=0 with 16'hFFFF, then read ra=0.
  - No load or oe bit is asserted.
  - `rsp_da=0`.
